// File: rtl/fib_inst_seq.sv
// Streams a MIPS Fibonacci/accumulate program (two addi seeds, n adds, drain NOPs)
// into a single-cycle CPU instruction port, one word per valid/ready handshake.
module fib_inst_seq #(
  parameter int          CNT_W      = 8,
  parameter logic [4:0]  REG_A      = 5'd1,
  parameter logic [4:0]  REG_B      = 5'd2,
  parameter logic [15:0] SEED_A     = 16'd1,
  parameter logic [15:0] SEED_B     = 16'd1,
  parameter int          DRAIN_NOPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] term_idx,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT_A = 3'd1,
    S_INIT_B = 3'd2,
    S_LOOP   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int DW = (DRAIN_NOPS > 1) ? $clog2(DRAIN_NOPS) : 1;

  state_t           r_state;
  state_t           w_next;
  state_t           w_post_work;
  logic             r_mode;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_term;
  logic [DW-1:0]    r_drain;
  logic             w_fire;
  logic             w_last_term;
  logic             w_last_nop;
  logic [4:0]       w_rd;

  // Handshake: a word transfers on a rising edge where inst_valid && inst_ready;
  // while valid is high and ready low, inst and all state/counters hold.
  assign w_fire      = inst_valid & inst_ready;
  assign w_last_term = (r_term == r_n - CNT_W'(1));
  assign w_last_nop  = (r_drain == DW'(DRAIN_NOPS - 1));
  assign w_post_work = (DRAIN_NOPS > 0) ? S_DRAIN : S_DONE;
  assign w_rd        = (r_mode || !r_term[0]) ? REG_A : REG_B;
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_INIT_A;
      S_INIT_A: if (w_fire) w_next = S_INIT_B;
      S_INIT_B: if (w_fire) w_next = (r_n != '0) ? S_LOOP : w_post_work;
      S_LOOP:   if (w_fire && w_last_term) w_next = w_post_work;
      S_DRAIN:  if (w_fire && w_last_nop) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Counters reload to zero on their final handshake so the next run starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= 1'b0;
      r_n     <= '0;
      r_term  <= '0;
      r_drain <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_mode <= mode;
        r_n    <= n_terms;
      end
      if (r_state == S_LOOP && w_fire)
        r_term <= w_last_term ? '0 : r_term + CNT_W'(1);
      if (r_state == S_DRAIN && w_fire)
        r_drain <= w_last_nop ? '0 : r_drain + DW'(1);
    end
  end

  always_comb begin
    inst       = '0;
    inst_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    term_idx   = '0;
    case (r_state)
      S_INIT_A: begin
        inst       = {6'b001000, 5'd0, REG_A, SEED_A};
        inst_valid = 1'b1;
        busy       = 1'b1;
      end
      S_INIT_B: begin
        inst       = {6'b001000, 5'd0, REG_B, SEED_B};
        inst_valid = 1'b1;
        busy       = 1'b1;
      end
      S_LOOP: begin
        inst       = {6'b000000, REG_A, REG_B, w_rd, 5'd0, 6'b100000};
        inst_valid = 1'b1;
        busy       = 1'b1;
        term_idx   = r_term;
      end
      S_DRAIN: begin
        inst_valid = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/fib_inst_seq.md
Name: fib_inst_seq

Overview:
- Synthesizable instruction sequencer that streams a MIPS Fibonacci (or accumulate) program into the single-cycle `cpu` Inst port.
- Replaces hand-written per-clock stimulus with a parametrised, runtime-configurable generator.
- Adds start/done control and a valid/ready handshake so the CPU side can stall the stream.
- Sits between bench/top-level control and `cpu`, one instruction per accepted handshake.

Parameters:
- CNT_W, 8, width of term counter and n_terms input
- REG_A, 5'd1, first working register (5 bits, must be nonzero and differ from REG_B)
- REG_B, 5'd2, second working register (5 bits, nonzero)
- SEED_A, 16'd1, addi immediate loaded into REG_A
- SEED_B, 16'd1, addi immediate loaded into REG_B
- DRAIN_NOPS, 1, number of 32'h0000_0000 NOPs emitted after the last add (0 allowed)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin program; sampled only in IDLE
- mode  in  1  captured at start: 0 = Fibonacci (alternate rd), 1 = accumulate (rd always REG_A)
- n_terms  in  CNT_W  number of add instructions, captured at start
- inst_ready  in  1  consumer accepts inst this cycle
- inst  out  32  instruction word
- inst_valid  out  1  inst is meaningful
- busy  out  1  high from cycle after accepted start until DONE
- done  out  1  one-cycle pulse at program end
- term_idx  out  CNT_W  index of the current add (0-based); 0 outside LOOP

Behaviour:
- Reset (synchronous, any state, including mid-program): state=IDLE, inst=0, inst_valid=0, busy=0, done=0, term_idx=0, captured mode/n cleared.
- States: IDLE -> INIT_A -> INIT_B -> LOOP -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 captures mode and n_terms; next cycle enters INIT_A with busy=1. All other states ignore start.
- INIT_A: inst = {6'b001000, 5'd0, REG_A, SEED_A}, valid=1. Advances on valid&ready.
- INIT_B: inst = {6'b001000, 5'd0, REG_B, SEED_B}, valid=1. Advances on handshake, to LOOP if n>0, else to DRAIN.
- LOOP: inst = {6'b000000, REG_A, REG_B, rd, 5'd0, 6'b100000}.
  - mode 0: rd = REG_A when term_idx even, REG_B when odd.
  - mode 1: rd = REG_A always.
  - term_idx increments on each handshake.
  - Leaves to DRAIN on the handshake where term_idx == n-1.
- DRAIN: inst=0, valid=1, emitted DRAIN_NOPS times (counted on handshakes). DRAIN_NOPS=0 skips directly to DONE.
- DONE: valid=0, inst=0, done=1 for exactly one cycle, busy=0. Next state is IDLE. A start in the DONE cycle is ignored.
- Handshake:
  - inst and valid are registered outputs.
  - While valid && !ready, inst is held stable and no state, counter or index advances.
  - One instruction is transferred per cycle when ready is held high.
- Latency:
  - First instruction is valid 1 cycle after the start sample.
  - With ready tied high, done pulses 2 + n + DRAIN_NOPS + 1 cycles after start.
- Counter: term_idx is CNT_W bits. n_terms = 2^CNT_W-1 is the maximum and must not wrap. n_terms=0 emits only the inits and NOPs.

Test Plan:
- Fib, ready tied 1, n=10, mode 0 -> stream is 0x20010001, 0x20020001, then 0x00220820/0x00221020 alternating ×10, then 0x00000000. With `cpu` attached, $1=89 and $2=144. done pulses once; busy is low afterward.
- Accumulate, n=4, mode 1 -> four 0x00220820 words; `cpu` ends with $1=5, $2=1.
- Backpressure: ready low for 3 cycles during term_idx=3 -> inst holds 0x00221020 stable and term_idx stays 3; stream resumes with no duplicated or lost words. Total accepted words = 13.
- n=0, DRAIN_NOPS=1 -> exactly 0x20010001, 0x20020001, 0x0, then the done pulse.
- Reset asserted mid-LOOP (term_idx=5) -> next cycle valid=0, inst=0, busy=0, IDLE. A following start replays from INIT_A.
- start held high through a whole run and during the DONE cycle -> only one program emitted; restart happens only from IDLE the cycle after DONE.
